mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have clock clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have reset rst, input, 1 bit: synchronous, active-high.
REQ-003 SHALL have mN_req (N=0,1), input, 1: requester N wants a 4-word burst; held high until mN_done.
REQ-004 SHALL have mN_cs, mN_we, input, 1 each: per-word RAM select/write from requester N.
REQ-005 SHALL have mN_addr, mN_din, input, 32 each: word address and write data from requester N.
REQ-006 SHALL have mN_gnt, output, 1, registered: requester N owns the RAM port.
REQ-007 SHALL have mN_ack, output, 1: word ack to requester N.
REQ-008 SHALL have mN_done, output, 1, registered: one-cycle pulse after requester N's 4th acked word.
REQ-009 SHALL have mN_dout, output, 32: read data to requester N.
REQ-010 SHALL have ram_cs, ram_we, output, 1 each; ram_addr, ram_din, output, 32 each: shared RAM request.
REQ-011 SHALL have ram_dout, input, 32; ram_ack, input, 1: RAM read data and word ack.
REQ-012 SHALL have ram_rst, output, 1: equals rst.

Function
REQ-013 SHALL implement states IDLE, OWN0, OWN1, RELEASE.
REQ-014 IDLE: if any mN_req sampled high, SHALL move to OWNn of the winner and set mn_gnt next cycle (1-cycle grant latency); otherwise stay.
REQ-015 In OWNn, ram_cs/ram_we/ram_addr/ram_din SHALL combinationally equal mn_cs/mn_we/mn_addr/mn_din; the other requester's inputs SHALL be ignored.
REQ-016 In IDLE and RELEASE, ram_cs and ram_we SHALL be 0; ram_addr and ram_din SHALL be 0.
REQ-017 mN_dout SHALL equal ram_dout for both requesters at all times.
REQ-018 mN_ack SHALL equal ram_ack AND mN_gnt; a non-owner SHALL never see ack.
REQ-019 A 2-bit word counter SHALL increment on each ram_ack in OWNn, wrapping 3->0.
REQ-020 On ram_ack with counter == 3, SHALL move to RELEASE, clear mn_gnt and pulse mn_done next cycle.
REQ-021 RELEASE SHALL last exactly one cycle, then IDLE; arbitration SHALL NOT occur in RELEASE.
REQ-022 Ownership SHALL NOT be preempted mid-burst, even if the owner drops mn_req; only 4 acks end ownership.
REQ-023 ram_ack in IDLE or RELEASE SHALL be ignored: no counter change, no mN_ack.
REQ-024 Simultaneous requests SHALL resolve per REQ-027/028.
REQ-025 m0_gnt and m1_gnt SHALL never be high together.

Reset
REQ-026 On rst high at a clock edge, including mid-burst: state SHALL be IDLE, counter 0, mN_gnt 0, mN_done 0, last-served flag 1, ram_cs/ram_we 0, ram_addr/ram_din 0.

Configuration
REQ-027 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests SHALL grant the requester not in the last-served flag; the flag updates to the owner on each grant; after reset m0 wins first.
REQ-028 Without ARB_ROUND_ROBIN_EN: on simultaneous requests m0 SHALL always win; the last-served flag SHALL be absent or unused.

Verification
REQ-029 Reset, m0_req=1 only, RAM acks every cycle: m0_gnt=1 at cycle 2; 4 m0_acks; m0_done pulse 1 cycle after 4th ack; m1_ack stays 0.
REQ-030 m0_req and m1_req both held, ARB_ROUND_ROBIN_EN defined: grant order m0,m1,m0,m1; one RELEASE cycle (gnt both 0) between bursts.
REQ-031 Same stimulus, macro undefined: m0 wins every burst; m1_gnt stays 0 while m0_req is held.
REQ-032 During OWN1, drive m0_cs=1, m0_addr=0x100 while m1_addr=0x2A0: ram_addr=0x2A0 throughout.
REQ-033 rst asserted after 2 acks of an m1 burst: next cycle m1_gnt=0, ram_cs=0; the following m0_req gets a full 4-ack burst.
REQ-034 ram_ack pulsed in IDLE with no requests: no mN_ack, counter stays 0, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-requester / single-RAM-port signal bundle for mem_arbiter
interface mem_arbiter_if;
  // requester 0
  logic        m0_req;
  logic        m0_cs;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_din;
  logic        m0_gnt;
  logic        m0_ack;
  logic        m0_done;
  logic [31:0] m0_dout;
  // requester 1
  logic        m1_req;
  logic        m1_cs;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_din;
  logic        m1_gnt;
  logic        m1_ack;
  logic        m1_done;
  logic [31:0] m1_dout;
  // shared RAM port
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_ack;
  logic        ram_rst;

  // arbiter side
  modport slave (
    input  m0_req, m0_cs, m0_we, m0_addr, m0_din,
    input  m1_req, m1_cs, m1_we, m1_addr, m1_din,
    input  ram_dout, ram_ack,
    output m0_gnt, m0_ack, m0_done, m0_dout,
    output m1_gnt, m1_ack, m1_done, m1_dout,
    output ram_cs, ram_we, ram_addr, ram_din, ram_rst
  );

  // requesters and RAM side
  modport master (
    output m0_req, m0_cs, m0_we, m0_addr, m0_din,
    output m1_req, m1_cs, m1_we, m1_addr, m1_din,
    output ram_dout, ram_ack,
    input  m0_gnt, m0_ack, m0_done, m0_dout,
    input  m1_gnt, m1_ack, m1_done, m1_dout,
    input  ram_cs, ram_we, ram_addr, ram_din, ram_rst
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester 4-word burst RAM arbiter; ARB_ROUND_ROBIN_EN selects round-robin tie-break (default: m0 priority)
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus_io
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN0    = 2'd1,
    OWN1    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       win1;

`ifdef ARB_ROUND_ROBIN_EN
  // last_q = 1 means m1 owned the most recent burst
  logic       last_q, last_d;

  // tie goes to whichever requester was not served last
  always_comb begin
    win1 = bus_io.m1_req & (~bus_io.m0_req | ~last_q);
  end
`else
  // fixed priority: m1 only wins when m0 is not asking
  always_comb begin
    win1 = bus_io.m1_req & ~bus_io.m0_req;
  end
`endif

  // state, counter, grant and done registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // next-state: arbitrate in IDLE, count acks while owned, one-cycle RELEASE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_io.m0_req | bus_io.m1_req) begin
          cnt_d = 2'd0;
          if (win1) begin
            state_d = OWN1;
            gnt1_d  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_d  = 1'b1;
`endif
          end else begin
            state_d = OWN0;
            gnt0_d  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_d  = 1'b0;
`endif
          end
        end
      end
      OWN0: begin
        if (bus_io.ram_ack) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = RELEASE;
            gnt0_d  = 1'b0;
            done0_d = 1'b1;
          end
        end
      end
      OWN1: begin
        if (bus_io.ram_ack) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = RELEASE;
            gnt1_d  = 1'b0;
            done1_d = 1'b1;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM request mux: owner's signals pass through, otherwise the port is quiet
  always_comb begin
    bus_io.ram_cs   = 1'b0;
    bus_io.ram_we   = 1'b0;
    bus_io.ram_addr = 32'd0;
    bus_io.ram_din  = 32'd0;
    case (state_q)
      OWN0: begin
        bus_io.ram_cs   = bus_io.m0_cs;
        bus_io.ram_we   = bus_io.m0_we;
        bus_io.ram_addr = bus_io.m0_addr;
        bus_io.ram_din  = bus_io.m0_din;
      end
      OWN1: begin
        bus_io.ram_cs   = bus_io.m1_cs;
        bus_io.ram_we   = bus_io.m1_we;
        bus_io.ram_addr = bus_io.m1_addr;
        bus_io.ram_din  = bus_io.m1_din;
      end
      default: begin
        bus_io.ram_cs   = 1'b0;
        bus_io.ram_we   = 1'b0;
        bus_io.ram_addr = 32'd0;
        bus_io.ram_din  = 32'd0;
      end
    endcase
  end

  assign bus_io.m0_gnt  = gnt0_q;
  assign bus_io.m1_gnt  = gnt1_q;
  assign bus_io.m0_done = done0_q;
  assign bus_io.m1_done = done1_q;
  assign bus_io.m0_ack  = bus_io.ram_ack & gnt0_q;
  assign bus_io.m1_ack  = bus_io.ram_ack & gnt1_q;
  assign bus_io.m0_dout = bus_io.ram_dout;
  assign bus_io.m1_dout = bus_io.ram_dout;
  assign bus_io.ram_rst = rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter against a burst-level reference model
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus_if ();

  mem_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  typedef struct packed {
    logic        gnt0;
    logic        gnt1;
    logic        ack0;
    logic        ack1;
    logic        done0;
    logic        done1;
    logic        rcs;
    logic        rwe;
    logic        rrst;
    logic [31:0] raddr;
    logic [31:0] rdin;
    logic [31:0] dout0;
    logic [31:0] dout1;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: who owns the port, how many words acked, release pending
  int m_owner = -1;
  int m_words = 0;
  bit m_rel   = 1'b0;
  int m_done  = -1;
  int m_last  = 1;

  function automatic obs_t model_out();
    obs_t o;
    o.gnt0  = (m_owner == 0);
    o.gnt1  = (m_owner == 1);
    o.ack0  = bus_if.ram_ack && (m_owner == 0);
    o.ack1  = bus_if.ram_ack && (m_owner == 1);
    o.done0 = (m_done == 0);
    o.done1 = (m_done == 1);
    o.rrst  = rst;
    o.dout0 = bus_if.ram_dout;
    o.dout1 = bus_if.ram_dout;
    if (m_owner == 0) begin
      o.rcs = bus_if.m0_cs; o.rwe = bus_if.m0_we; o.raddr = bus_if.m0_addr; o.rdin = bus_if.m0_din;
    end else if (m_owner == 1) begin
      o.rcs = bus_if.m1_cs; o.rwe = bus_if.m1_we; o.raddr = bus_if.m1_addr; o.rdin = bus_if.m1_din;
    end else begin
      o.rcs = 1'b0; o.rwe = 1'b0; o.raddr = 32'd0; o.rdin = 32'd0;
    end
    return o;
  endfunction

  task automatic model_update();
    int w;
    if (rst) begin
      m_owner = -1; m_words = 0; m_rel = 1'b0; m_done = -1; m_last = 1;
    end else begin
      m_done = -1;
      if (m_owner >= 0) begin
        if (bus_if.ram_ack) begin
          m_words++;
          if (m_words == 4) begin
            m_done  = m_owner;
            m_owner = -1;
            m_words = 0;
            m_rel   = 1'b1;
          end
        end
      end else if (m_rel) begin
        m_rel = 1'b0;
      end else if (bus_if.m0_req || bus_if.m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (bus_if.m0_req && bus_if.m1_req) w = 1 - m_last;
        else w = bus_if.m1_req ? 1 : 0;
`else
        w = bus_if.m0_req ? 0 : 1;
`endif
        m_owner = w;
        m_last  = w;
        m_words = 0;
      end
    end
  endtask

  // one clock: publish expectation for this cycle, then advance the model at the edge
  task automatic step(input bit chk);
    if (chk) exp_q.push_back(model_out());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_data();
    bus_if.m0_cs    = 1'($urandom);
    bus_if.m0_we    = 1'($urandom);
    bus_if.m0_addr  = $urandom;
    bus_if.m0_din   = $urandom;
    bus_if.m1_cs    = 1'($urandom);
    bus_if.m1_we    = 1'($urandom);
    bus_if.m1_addr  = $urandom;
    bus_if.m1_din   = $urandom;
    bus_if.ram_dout = $urandom;
  endtask

  task automatic quiet();
    bus_if.m0_req = 1'b0; bus_if.m1_req = 1'b0;
    bus_if.ram_ack = 1'b0;
    rand_data();
  endtask

  // monitor: compare every presented cycle against the oldest expectation
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.gnt0  = bus_if.m0_gnt;  a.gnt1  = bus_if.m1_gnt;
        a.ack0  = bus_if.m0_ack;  a.ack1  = bus_if.m1_ack;
        a.done0 = bus_if.m0_done; a.done1 = bus_if.m1_done;
        a.rcs   = bus_if.ram_cs;  a.rwe   = bus_if.ram_we;
        a.rrst  = bus_if.ram_rst;
        a.raddr = bus_if.ram_addr; a.rdin = bus_if.ram_din;
        a.dout0 = bus_if.m0_dout; a.dout1 = bus_if.m1_dout;
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cycle_obs t=%0t got gnt=%b%b ack=%b%b done=%b%b cs=%b we=%b rst=%b addr=%h din=%h dout=%h/%h ; want gnt=%b%b ack=%b%b done=%b%b cs=%b we=%b rst=%b addr=%h din=%h dout=%h/%h",
                   $time, a.gnt0, a.gnt1, a.ack0, a.ack1, a.done0, a.done1, a.rcs, a.rwe, a.rrst,
                   a.raddr, a.rdin, a.dout0, a.dout1,
                   e.gnt0, e.gnt1, e.ack0, e.ack1, e.done0, e.done1, e.rcs, e.rwe, e.rrst,
                   e.raddr, e.rdin, e.dout0, e.dout1);
        end
      end
    end
  end

  // stimulus
  initial begin
    int cnt;
    quiet();
    rst = 1'b1;
    #1;
    step(1'b0);
    step(1'b1);
    rst = 1'b0;

    // single m0 burst, RAM acks every cycle
    bus_if.m0_req = 1'b1; bus_if.ram_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      step(1'b1);
      if (m_done == 0) bus_if.m0_req = 1'b0;
    end

    // both requesting continuously: four bursts
    bus_if.m0_req = 1'b1; bus_if.m1_req = 1'b1; bus_if.ram_ack = 1'b1;
    for (int i = 0; i < 26; i++) begin
      rand_data();
      step(1'b1);
    end
    quiet();
    for (int i = 0; i < 3; i++) step(1'b1);

    // m1 owns; m0 drives a competing address that must not leak through
    bus_if.m1_req = 1'b1;
    cnt = 0;
    while (m_owner != 1 && cnt < 8) begin step(1'b1); cnt++; end
    bus_if.m0_cs = 1'b1; bus_if.m0_addr = 32'h100;
    bus_if.m1_cs = 1'b1; bus_if.m1_addr = 32'h2A0;
    bus_if.m0_req = 1'b1; bus_if.ram_ack = 1'b1;
    cnt = 0;
    while (m_owner == 1 && cnt < 8) begin step(1'b1); cnt++; end
    quiet();
    for (int i = 0; i < 8; i++) step(1'b1);

    // reset in the middle of an m1 burst, then a full m0 burst
    bus_if.m1_req = 1'b1; bus_if.ram_ack = 1'b1;
    cnt = 0;
    while (!(m_owner == 1 && m_words == 2) && cnt < 12) begin rand_data(); step(1'b1); cnt++; end
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    bus_if.m1_req = 1'b0; bus_if.m0_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      step(1'b1);
      if (m_done == 0) bus_if.m0_req = 1'b0;
    end

    // stray RAM acks with nobody owning, then a burst must still need 4 acks
    quiet();
    bus_if.ram_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_data(); step(1'b1); end
    bus_if.m0_req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rand_data();
      bus_if.ram_ack = ($urandom_range(0, 2) != 0);
      step(1'b1);
      if (m_done == 0) bus_if.m0_req = 1'b0;
    end

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      bus_if.m0_req  = ($urandom_range(0, 3) != 0);
      bus_if.m1_req  = ($urandom_range(0, 3) != 0);
      bus_if.ram_ack = ($urandom_range(0, 9) < 6);
      rst            = ($urandom_range(0, 299) == 0);
      step(1'b1);
    end
    rst = 1'b0;
    quiet();
    step(1'b1);
    repeat (3) @(negedge clk);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
